// File: rtl/tm_driver_pkg.sv
// Shared state encoding and default timing for the Turing-machine program driver.
package tm_driver_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD_WAIT,
      ST_LOAD_HI,
      ST_LOAD_LO,
      ST_DONE_PULSE,
      ST_GAP,
      ST_RUN_HI,
      ST_RUN_LO,
      ST_FINISHED,
      ST_TIMEOUT
   } state_t;

   localparam int HI_CYC_DEF    = 2;
   localparam int LO_CYC_DEF    = 4;
   localparam int MAX_STEPS_DEF = 1000;

endpackage

// File: rtl/tm_phase_timer.sv
// Loadable down-counter; expire pulses for one cycle on the last cycle of a loaded phase.
module tm_phase_timer #(
   parameter int TW = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          expire
);

   logic [TW-1:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == TW'(1));

endmodule

// File: rtl/tm_program_driver.sv
// Feeds program words to the Turing-machine core as timed Next pulses, then steps it until done.
//
// state          | meaning
// ---------------+-------------------------------------------------------------
// ST_IDLE        | waiting for start after reset
// ST_LOAD_WAIT   | prog_ready high, waiting for a program word
// ST_LOAD_HI     | next high HI_CYC cycles carrying the accepted word
// ST_LOAD_LO     | next low LO_CYC cycles; then next word or done pulse
// ST_DONE_PULSE  | done high for one cycle
// ST_GAP         | LO_CYC quiet cycles before the first run step
// ST_RUN_HI      | run-phase next high HI_CYC cycles; step_count bumps on exit
// ST_RUN_LO      | run-phase next low LO_CYC cycles
// ST_FINISHED    | core reported compute_done; holds until start
// ST_TIMEOUT     | MAX_STEPS issued without compute_done; holds until start
module tm_program_driver
   import tm_driver_pkg::*;
#(
   parameter int DW        = 4,
   parameter int HI_CYC    = HI_CYC_DEF,
   parameter int LO_CYC    = LO_CYC_DEF,
   parameter int MAX_STEPS = MAX_STEPS_DEF,
   parameter int SW        = $clog2(MAX_STEPS + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic [DW-1:0] prog_word,
   input  logic          prog_valid,
   input  logic          prog_last,
   output logic          prog_ready,
   input  logic          compute_done,
   output logic [DW-1:0] input_data,
   output logic          next,
   output logic          done,
   output logic          busy,
   output logic          finished,
   output logic          timeout,
   output logic [SW-1:0] step_count
);

   localparam int            TW       = $clog2(((HI_CYC > LO_CYC) ? HI_CYC : LO_CYC) + 1);
   localparam logic [TW-1:0] HI_LD    = TW'(HI_CYC);
   localparam logic [TW-1:0] LO_LD    = TW'(LO_CYC);
   localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEPS);

   state_t        state;
   logic          last_q;
   logic          expire;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic [SW-1:0] step_inc;

   assign prog_ready = (state == ST_LOAD_WAIT);
   assign step_inc   = (step_count == STEP_MAX) ? step_count : step_count + 1'b1;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = LO_LD;
      case (state)
         ST_LOAD_WAIT: begin
            tmr_load = prog_valid;
            tmr_val  = HI_LD;
         end
         ST_LOAD_HI, ST_RUN_HI: tmr_load = expire;
         ST_DONE_PULSE:         tmr_load = 1'b1;
         ST_GAP, ST_RUN_LO: begin
            tmr_load = expire;
            tmr_val  = HI_LD;
         end
         default: ;
      endcase
   end

   tm_phase_timer #(.TW(TW)) u_timer (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (expire)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         input_data <= '0;
         last_q     <= 1'b0;
         next       <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         finished   <= 1'b0;
         timeout    <= 1'b0;
         step_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  state <= ST_LOAD_WAIT;
               end
            end
            ST_LOAD_WAIT: begin
               if (prog_valid) begin
                  input_data <= prog_word;
                  last_q     <= prog_last;
                  next       <= 1'b1;
                  state      <= ST_LOAD_HI;
               end
            end
            ST_LOAD_HI: begin
               if (expire) begin
                  next  <= 1'b0;
                  state <= ST_LOAD_LO;
               end
            end
            ST_LOAD_LO: begin
               if (expire) begin
                  if (last_q) begin
                     done  <= 1'b1;
                     state <= ST_DONE_PULSE;
                  end else begin
                     state <= ST_LOAD_WAIT;
                  end
               end
            end
            ST_DONE_PULSE: begin
               done  <= 1'b0;
               state <= ST_GAP;
            end
            ST_GAP, ST_RUN_LO: begin
               if (compute_done) begin
                  finished <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_FINISHED;
               end else if (expire) begin
                  next  <= 1'b1;
                  state <= ST_RUN_HI;
               end
            end
            ST_RUN_HI: begin
               // The step still counts when compute_done lands on the exit cycle.
               if (expire) begin
                  step_count <= step_inc;
               end
               if (compute_done) begin
                  next     <= 1'b0;
                  finished <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_FINISHED;
               end else if (expire) begin
                  next <= 1'b0;
                  if (step_inc == STEP_MAX) begin
                     timeout <= 1'b1;
                     busy    <= 1'b0;
                     state   <= ST_TIMEOUT;
                  end else begin
                     state <= ST_RUN_LO;
                  end
               end
            end
            ST_FINISHED, ST_TIMEOUT: begin
               if (start) begin
                  finished   <= 1'b0;
                  timeout    <= 1'b0;
                  step_count <= '0;
                  busy       <= 1'b1;
                  state      <= ST_LOAD_WAIT;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tm_program_driver.sv
// Directed bench for tm_program_driver: load shaping, stall, finish, timeout, tie and async reset.
module tb_tm_program_driver;

   localparam int DW  = 4;
   localparam int HI  = 2;
   localparam int LO  = 4;
   localparam int MAX = 8;
   localparam int SW  = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] prog_word = '0;
   logic          prog_valid = 1'b0;
   logic          prog_last = 1'b0;
   logic          compute_done = 1'b0;
   logic          prog_ready;
   logic [DW-1:0] input_data;
   logic          next;
   logic          done;
   logic          busy;
   logic          finished;
   logic          timeout;
   logic [SW-1:0] step_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   tm_program_driver #(
      .DW(DW), .HI_CYC(HI), .LO_CYC(LO), .MAX_STEPS(MAX), .SW(SW)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .prog_word    (prog_word),
      .prog_valid   (prog_valid),
      .prog_last    (prog_last),
      .prog_ready   (prog_ready),
      .compute_done (compute_done),
      .input_data   (input_data),
      .next         (next),
      .done         (done),
      .busy         (busy),
      .finished     (finished),
      .timeout      (timeout),
      .step_count   (step_count)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Hand one word over, then measure its Next pulse; returns at LOAD_WAIT or DONE_PULSE.
   task automatic send_word(input logic [DW-1:0] w, input logic last, input string tag);
      int hi;
      int lo;
      int wt;
      int bad;
      hi = 0; lo = 0; wt = 0; bad = 0;
      prog_word  = w;
      prog_last  = last;
      prog_valid = 1'b1;
      while (!prog_ready && wt < 50) begin
         tick();
         wt++;
      end
      check_eq({tag, " ready"}, int'(prog_ready), 1);
      tick();
      prog_valid = 1'b0;
      prog_last  = 1'b0;
      prog_word  = ~w;
      while (next && hi < 20) begin
         if (input_data !== w || prog_ready) bad++;
         hi++;
         tick();
      end
      while (!prog_ready && !done && lo < 20) begin
         if (next || input_data !== w) bad++;
         lo++;
         tick();
      end
      check_eq({tag, " hi"}, hi, HI);
      check_eq({tag, " lo"}, lo, LO);
      check_eq({tag, " stable"}, bad, 0);
   endtask

   // Advance until n run pulses have ended; pulse widths and gaps are checked on the way.
   task automatic run_until_fall(input int n, input string tag);
      int   falls;
      int   hi;
      int   lo;
      int   shape_bad;
      int   cyc;
      logic prev;
      falls = 0; hi = 0; lo = 0; shape_bad = 0; cyc = 0;
      prev = next;
      while (falls < n && cyc < 500) begin
         tick();
         cyc++;
         if (next) begin
            if (!prev && falls > 0 && lo != LO) shape_bad++;
            hi++;
            lo = 0;
         end else begin
            if (prev) begin
               falls++;
               if (hi != HI) shape_bad++;
               hi = 0;
            end
            lo++;
         end
         prev = next;
      end
      check_eq({tag, " reached"}, falls, n);
      check_eq({tag, " shape"}, shape_bad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int pulses;
      int cyc;
      logic prev;

      // reset
      repeat (3) tick();
      check_eq("rst next", int'(next), 0);
      check_eq("rst done", int'(done), 0);
      check_eq("rst busy", int'(busy), 0);
      check_eq("rst flags", int'({finished, timeout}), 0);
      check_eq("rst step", int'(step_count), 0);
      check_eq("rst data", int'(input_data), 0);
      check_eq("rst ready", int'(prog_ready), 0);
      reset_n = 1'b1;
      tick();
      check_eq("idle ready", int'(prog_ready), 0);

      // session 1: three-word load with a stall, finish during 5th RUN_LO
      pulse_start();
      check_eq("s1 busy", int'(busy), 1);
      check_eq("s1 ready", int'(prog_ready), 1);
      send_word(4'h1, 1'b0, "w0");
      send_word(4'h6, 1'b0, "w1");
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (next || input_data !== 4'h6 || !prog_ready) bad++;
         tick();
      end
      check_eq("stall", bad, 0);
      send_word(4'hA, 1'b1, "w2");
      check_eq("done hi", int'(done), 1);
      check_eq("done next", int'(next), 0);
      tick();
      check_eq("done lo", int'(done), 0);
      check_eq("gap busy", int'(busy), 1);
      run_until_fall(2, "s1a");
      check_eq("s1 step2", int'(step_count), 2);
      pulse_start();
      check_eq("ign busy", int'(busy), 1);
      check_eq("ign step", int'(step_count), 2);
      check_eq("ign ready", int'(prog_ready), 0);
      run_until_fall(3, "s1b");
      check_eq("s1 step5", int'(step_count), 5);
      compute_done = 1'b1;
      tick();
      compute_done = 1'b0;
      check_eq("fin flag", int'(finished), 1);
      check_eq("fin timeout", int'(timeout), 0);
      check_eq("fin busy", int'(busy), 0);
      check_eq("fin next", int'(next), 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (next) bad++;
         tick();
      end
      check_eq("fin quiet", bad, 0);
      check_eq("fin step hold", int'(step_count), 5);
      check_eq("fin hold", int'(finished), 1);

      // session 2: single-word program, runs into timeout
      pulse_start();
      check_eq("s2 clr fin", int'(finished), 0);
      check_eq("s2 clr step", int'(step_count), 0);
      check_eq("s2 ready", int'(prog_ready), 1);
      send_word(4'h3, 1'b1, "w3");
      check_eq("s2 done", int'(done), 1);
      pulses = 0; cyc = 0; prev = next;
      while (!timeout && cyc < 300) begin
         tick();
         if (next && !prev) pulses++;
         prev = next;
         cyc++;
      end
      check_eq("to flag", int'(timeout), 1);
      check_eq("to pulses", pulses, MAX);
      check_eq("to step", int'(step_count), MAX);
      check_eq("to finished", int'(finished), 0);
      check_eq("to busy", int'(busy), 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (next) bad++;
         tick();
      end
      check_eq("to quiet", bad, 0);
      check_eq("to step hold", int'(step_count), MAX);

      // session 3: compute_done on the same cycle as the final increment
      pulse_start();
      check_eq("s3 clr to", int'(timeout), 0);
      send_word(4'h5, 1'b1, "w4");
      pulses = 0; cyc = 0; prev = next;
      while (pulses < MAX && cyc < 300) begin
         tick();
         if (next && !prev) pulses++;
         prev = next;
         cyc++;
      end
      check_eq("tie step7", int'(step_count), MAX - 1);
      tick();
      check_eq("tie hi2", int'(next), 1);
      compute_done = 1'b1;
      tick();
      compute_done = 1'b0;
      check_eq("tie finished", int'(finished), 1);
      check_eq("tie timeout", int'(timeout), 0);
      check_eq("tie step", int'(step_count), MAX);
      check_eq("tie next", int'(next), 0);

      // session 4: asynchronous reset in the middle of RUN_HI
      pulse_start();
      send_word(4'h9, 1'b1, "w5");
      run_until_fall(2, "s4");
      cyc = 0;
      while (!next && cyc < 20) begin
         tick();
         cyc++;
      end
      check_eq("s4 in hi", int'(next), 1);
      start = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("ar next", int'(next), 0);
      check_eq("ar done", int'(done), 0);
      check_eq("ar busy", int'(busy), 0);
      check_eq("ar step", int'(step_count), 0);
      check_eq("ar ready", int'(prog_ready), 0);
      start = 1'b0;
      #1;
      reset_n = 1'b1;
      repeat (3) tick();
      check_eq("ar idle busy", int'(busy), 0);
      check_eq("ar idle ready", int'(prog_ready), 0);
      pulse_start();
      check_eq("ar restart", int'(prog_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
